// File: rtl/d_pkg.sv
// Shared decode-stage definitions: opcodes, pcsel/forwarding encodings, nop.
package d_pkg;
  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BGEZALR  = 6'b111111;
  localparam logic [5:0] FN_JR       = 6'b001000;
  localparam logic [5:0] FN_JALR     = 6'b001001;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [2:0] {
    PCSEL_PC4     = 3'd0,
    PCSEL_BR      = 3'd1,
    PCSEL_J       = 3'd2,
    PCSEL_JR      = 3'd3,
    PCSEL_BGEZALR = 3'd4
  } pcsel_e;

  typedef enum logic [1:0] {
    FWD_GRF   = 2'd0,
    FWD_PC8_E = 2'd1,
    FWD_ALU_M = 2'd2,
    FWD_WD_W  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    pcsel_e pcsel;
    logic   isbeq;
    logic   equal;
    logic   da;
  } br_resp_t;

  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] grf,
                                          input logic [31:0] pc8, input logic [31:0] alu,
                                          input logic [31:0] wd);
    case (sel)
      FWD_PC8_E: return pc8;
      FWD_ALU_M: return alu;
      FWD_WD_W:  return wd;
      default:   return grf;
    endcase
  endfunction
endpackage

// File: rtl/d_branch_unit.sv
// Combinational next-PC decode and operand compare for the D stage.
// Optional bgezalr decode enabled by D_BGEZALR_EN.
module d_branch_unit
  import d_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output br_resp_t    resp
);
  always_comb begin
    resp.pcsel = PCSEL_PC4;
    resp.isbeq = 1'b0;
    resp.equal = (rs == rt);
`ifdef D_BGEZALR_EN
    resp.da    = ~rs[31];
`else
    resp.da    = 1'b0;
`endif
    case (op)
      OP_BEQ: begin
        resp.pcsel = PCSEL_BR;
        resp.isbeq = 1'b1;
      end
      OP_J, OP_JAL: resp.pcsel = PCSEL_J;
      OP_SPECIAL:
        if (funct == FN_JR || funct == FN_JALR) resp.pcsel = PCSEL_JR;
`ifdef D_BGEZALR_EN
      OP_BGEZALR: resp.pcsel = PCSEL_BGEZALR;
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/d_stage.sv
// IF/ID pipeline register with forwarded operand read and branch/jump resolution.
// D_BGEZALR_EN enables the bgezalr decode in d_branch_unit.
module d_stage
  import d_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic        flush,
  input  logic [31:0] IR_F,
  input  logic [31:0] pc4_F,
  input  logic [31:0] grf_rs,
  input  logic [31:0] grf_rt,
  input  logic [1:0]  fwd_rs_sel,
  input  logic [1:0]  fwd_rt_sel,
  input  logic [31:0] pc8_E,
  input  logic [31:0] alu_M,
  input  logic [31:0] wd_W,
  output logic [31:0] IR_D,
  output logic [31:0] pc4_D,
  output logic [31:0] pc8_D,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [31:0] rs,
  output logic [31:0] rt,
  output logic [15:0] imm16,
  output logic [25:0] imm26,
  output logic [2:0]  pcsel,
  output logic        equal,
  output logic        isbeq,
  output logic        da
);
  localparam int NUM_OPS = 2;

  logic [NUM_OPS-1:0][31:0] grf_val, opnd;
  logic [NUM_OPS-1:0][1:0]  fwd_sel;
  br_resp_t                 br;

  // flush beats stop; reset beats both
  always_ff @(posedge clk) begin
    if (!reset) begin
      IR_D  <= NOP;
      pc4_D <= PC_RESET;
    end else if (flush) begin
      IR_D  <= NOP;
    end else if (!stop) begin
      IR_D  <= IR_F;
      pc4_D <= pc4_F;
    end
  end

  assign grf_val = {grf_rt, grf_rs};
  assign fwd_sel = {fwd_rt_sel, fwd_rs_sel};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    assign opnd[i] = fwd_mux(fwd_sel[i], grf_val[i], pc8_E, alu_M, wd_W);
  end

  assign rs      = opnd[0];
  assign rt      = opnd[1];
  assign pc8_D   = pc4_D + 32'd4;
  assign rs_addr = IR_D[25:21];
  assign rt_addr = IR_D[20:16];
  assign imm16   = IR_D[15:0];
  assign imm26   = IR_D[25:0];

  d_branch_unit u_br (
    .op    (IR_D[31:26]),
    .funct (IR_D[5:0]),
    .rs    (rs),
    .rt    (rt),
    .resp  (br)
  );

  assign pcsel = br.pcsel;
  assign isbeq = br.isbeq;
  assign equal = br.equal;
  assign da    = br.da;
endmodule

// File: tb/tb_d_stage.sv
// Self-checking bench for d_stage: directed steps then randomized cycles vs a reference model.
module tb_d_stage;
  logic        clk = 1'b0;
  logic        reset, stop, flush;
  logic [31:0] IR_F, pc4_F, grf_rs, grf_rt, pc8_E, alu_M, wd_W;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] IR_D, pc4_D, pc8_D, rs, rt;
  logic [4:0]  rs_addr, rt_addr;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [2:0]  pcsel;
  logic        equal, isbeq, da;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_ir, m_pc4, held_ir, held_pc4;

  always #5 clk = ~clk;

  d_stage #(.PC_RESET(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .stop(stop), .flush(flush), .IR_F(IR_F), .pc4_F(pc4_F),
    .grf_rs(grf_rs), .grf_rt(grf_rt), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .pc8_E(pc8_E), .alu_M(alu_M), .wd_W(wd_W), .IR_D(IR_D), .pc4_D(pc4_D), .pc8_D(pc8_D),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs(rs), .rt(rt), .imm16(imm16), .imm26(imm26),
    .pcsel(pcsel), .equal(equal), .isbeq(isbeq), .da(da)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_opnd(input logic [1:0] sel, input logic [31:0] grf);
    if (sel == 2'd1) return pc8_E;
    if (sel == 2'd2) return alu_M;
    if (sel == 2'd3) return wd_W;
    return grf;
  endfunction

  function automatic logic [31:0] ref_pcsel(input logic [31:0] ir);
    logic [5:0] op, fn;
    op = ir[31:26];
    fn = ir[5:0];
    if (op == 6'd4) return 32'd1;
    if (op == 6'd2 || op == 6'd3) return 32'd2;
    if (op == 6'd0 && (fn == 6'd8 || fn == 6'd9)) return 32'd3;
`ifdef D_BGEZALR_EN
    if (op == 6'd63) return 32'd4;
`endif
    return 32'd0;
  endfunction

  task automatic check_all();
    logic [31:0] ers, ert;
    ers = ref_opnd(fwd_rs_sel, grf_rs);
    ert = ref_opnd(fwd_rt_sel, grf_rt);
    chk("IR_D", IR_D, m_ir);
    chk("pc4_D", pc4_D, m_pc4);
    chk("pc8_D", pc8_D, m_pc4 + 32'd4);
    chk("rs_addr", 32'(rs_addr), 32'(m_ir[25:21]));
    chk("rt_addr", 32'(rt_addr), 32'(m_ir[20:16]));
    chk("imm16", 32'(imm16), 32'(m_ir[15:0]));
    chk("imm26", 32'(imm26), 32'(m_ir[25:0]));
    chk("rs", rs, ers);
    chk("rt", rt, ert);
    chk("pcsel", 32'(pcsel), ref_pcsel(m_ir));
    chk("isbeq", 32'(isbeq), 32'(m_ir[31:26] == 6'd4));
    chk("equal", 32'(equal), 32'(ers == ert));
`ifdef D_BGEZALR_EN
    chk("da", 32'(da), 32'(!ers[31]));
`else
    chk("da", 32'(da), 32'd0);
`endif
  endtask

  // One clock: advance the model with the inputs present at the edge, then check.
  task automatic step();
    @(posedge clk);
    if (!reset) begin
      m_ir = 32'd0; m_pc4 = 32'h0000_3000;
    end else if (flush) begin
      m_ir = 32'd0;
    end else if (!stop) begin
      m_ir = IR_F; m_pc4 = pc4_F;
    end
    #1;
    check_all();
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return {6'd4, r[25:0]};
      1: return {6'd2, r[25:0]};
      2: return {6'd3, r[25:0]};
      3: return {6'd0, r[25:6], 6'd8};
      4: return {6'd0, r[25:6], 6'd9};
      5: return {6'd63, r[25:0]};
      6: return {6'd0, r[25:0]};
      default: return r;
    endcase
  endfunction

  task automatic rand_operands();
    grf_rs = $urandom; pc8_E = $urandom; alu_M = $urandom; wd_W = $urandom;
    grf_rt = ($urandom_range(0, 2) == 0) ? grf_rs : $urandom;
    if ($urandom_range(0, 3) == 0) alu_M = grf_rs;
    if ($urandom_range(0, 3) == 0) grf_rs = 32'h8000_0000 | grf_rs;
    fwd_rs_sel = 2'($urandom_range(0, 3));
    fwd_rt_sel = 2'($urandom_range(0, 3));
  endtask

  initial begin
    m_ir = '0; m_pc4 = '0;
    reset = 1'b0; stop = 1'b0; flush = 1'b0;
    IR_F = 32'h1234_5678; pc4_F = 32'h0000_5555;
    grf_rs = '0; grf_rt = '0; pc8_E = '0; alu_M = '0; wd_W = '0;
    fwd_rs_sel = 2'd0; fwd_rt_sel = 2'd0;

    // reset
    step();
    chk("rst_IR_D", IR_D, 32'd0);
    chk("rst_pc4_D", pc4_D, 32'h0000_3000);
    chk("rst_pcsel", 32'(pcsel), 32'd0);

    // beq $1,$2 with equal operands, then forwarded mismatch
    reset = 1'b1; IR_F = 32'h1022_0003; pc4_F = 32'h0000_3004;
    step();
    grf_rs = 32'd5; grf_rt = 32'd5; #1;
    check_all();
    chk("beq_isbeq", 32'(isbeq), 32'd1);
    chk("beq_pcsel", 32'(pcsel), 32'd1);
    chk("beq_equal", 32'(equal), 32'd1);
    chk("beq_pc8", pc8_D, 32'h0000_3008);
    fwd_rt_sel = 2'd2; alu_M = 32'd6; #1;
    chk("beq_fwd_equal", 32'(equal), 32'd0);
    chk("beq_fwd_rt", rt, 32'd6);

    // stall holds for three cycles, then release captures
    held_ir = IR_D; held_pc4 = pc4_D;
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IR_F = 32'hAAAA_0000 + 32'(i); pc4_F = 32'h0000_4000 + 32'(4 * i);
      step();
      chk("stall_IR_D", IR_D, held_ir);
      chk("stall_pc4_D", pc4_D, held_pc4);
    end
    stop = 1'b0; IR_F = 32'h0800_0C00; pc4_F = 32'h0000_3010;
    step();
    chk("release_IR_D", IR_D, 32'h0800_0C00);
    chk("release_pcsel", 32'(pcsel), 32'd2);

    // stop and flush together: flush wins, pc4_D holds
    stop = 1'b1; flush = 1'b1; IR_F = 32'hDEAD_BEEF; pc4_F = 32'h0000_7777;
    step();
    chk("flush_IR_D", IR_D, 32'd0);
    chk("flush_pc4_D", pc4_D, 32'h0000_3010);

    // reset during stall
    flush = 1'b0; reset = 1'b0;
    step();
    chk("rst_stall_pc4_D", pc4_D, 32'h0000_3000);

    // jr $31 with rs forwarded from E-stage pc8
    reset = 1'b1; stop = 1'b0; IR_F = 32'h03E0_0008; pc4_F = 32'h0000_3020;
    step();
    fwd_rs_sel = 2'd1; pc8_E = 32'h0000_3050; #1;
    check_all();
    chk("jr_pcsel", 32'(pcsel), 32'd3);
    chk("jr_rs", rs, 32'h0000_3050);

    // op 111111 with negative then zero rs
    IR_F = 32'hFC1F_0000; pc4_F = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc8", pc8_D, 32'h0000_0000);
    fwd_rs_sel = 2'd0; grf_rs = 32'h8000_0000; #1;
    check_all();
    grf_rs = 32'd0; #1;
    check_all();
`ifdef D_BGEZALR_EN
    chk("bgez_pcsel", 32'(pcsel), 32'd4);
    chk("bgez_da", 32'(da), 32'd1);
`else
    chk("bgez_off_pcsel", 32'(pcsel), 32'd0);
    chk("bgez_off_da", 32'(da), 32'd0);
`endif

    // randomized cycles
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) != 0);
      flush = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 4) == 0);
      IR_F  = rand_ir();
      pc4_F = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      rand_operands();
      step();
      rand_operands(); #1;
      check_all();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
